// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcode values, FSM state
// encoding, request mode field layout and the legal-opcode check.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;  // add, or subtract when eq=0
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_EPAR   = 4'b0101;

  // mode = {eq, ltgt[2:0]}
  localparam int MODE_EQ_BIT   = 3;
  localparam int MODE_LTGT_MSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_BRANCH, OP_EPAR: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_sequencer_rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
//   i_valid0/i_valid1 : pending requests
//   i_last_grant      : id granted most recently
//   o_grant_valid     : some request is granted
//   o_grant_id        : which one (meaningful only with o_grant_valid)
module alu_sequencer_rr_arbiter2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);

  // On contention the requester that did not win last time goes next.
  assign o_grant_valid = i_valid0 | i_valid1;
  assign o_grant_id    = (i_valid0 & i_valid1) ? ~i_last_grant : i_valid1;

endmodule

// File: rtl/alu_sequencer.sv
// Arbitrates two requesters onto one shared combinational ALU, holds the
// ALU inputs for SETTLE_CYCLES, captures the result and returns it on a
// valid/ready response channel tagged with the requester id.
//   clock, reset_n            : clock (rising edge), async active-low reset
//   reqN_valid/ready/op/a/b/mode : request channels, N = 0 (decode) / 1 (parity)
//   rsp_valid/ready/id/data/flag/err : response channel
//   alu_op/res/register/eq/ltgt : registered ALU inputs
//   alu_out/alu_compres       : ALU results
//
// state  | meaning
// IDLE   | waiting for a request; grant asserted combinationally
// ISSUE  | drive latched request onto ALU inputs, load settle counter
// SETTLE | ALU inputs stable; capture result on the last count
// RESP   | response valid until consumer accepts it
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int WIDTH         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] alu_register,
  output logic             alu_eq,
  output logic [2:0]       alu_ltgt,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_compres
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_mode;
  logic             r_id;
  logic [3:0]       r_cnt;
  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_res;
  logic [WIDTH-1:0] r_alu_reg;
  logic             r_alu_eq;
  logic [2:0]       r_alu_ltgt;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_flag;
  logic             r_rsp_err;

  logic             w_grant_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic [3:0]       w_req_op;
  logic [WIDTH-1:0] w_req_a;
  logic [WIDTH-1:0] w_req_b;
  logic [3:0]       w_req_mode;
  logic             w_req_legal;

  alu_sequencer_rr_arbiter2 u_arb (
    .i_valid0      (req0_valid),
    .i_valid1      (req1_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_accept    = (r_state == ST_IDLE) & w_grant_valid;
  assign w_req_op    = w_grant_id ? req1_op   : req0_op;
  assign w_req_a     = w_grant_id ? req1_a    : req0_a;
  assign w_req_b     = w_grant_id ? req1_b    : req0_b;
  assign w_req_mode  = w_grant_id ? req1_mode : req0_mode;
  assign w_req_legal = is_legal_op(w_req_op);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        // Illegal opcodes never touch the ALU; answer with an error at once.
        if (w_grant_valid) w_next_state = w_req_legal ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE:  w_next_state = ST_SETTLE;
      ST_SETTLE: if (r_cnt <= 4'd1) w_next_state = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = w_accept & ~w_grant_id;
    req1_ready = w_accept &  w_grant_id;
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign rsp_flag     = r_rsp_flag;
  assign rsp_err      = r_rsp_err;
  assign alu_op       = r_alu_op;
  assign alu_res      = r_alu_res;
  assign alu_register = r_alu_reg;
  assign alu_eq       = r_alu_eq;
  assign alu_ltgt     = r_alu_ltgt;

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_mode       <= '0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_alu_op     <= '0;
      r_alu_res    <= '0;
      r_alu_reg    <= '0;
      r_alu_eq     <= 1'b0;
      r_alu_ltgt   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_flag   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_op         <= w_req_op;
            r_a          <= w_req_a;
            r_b          <= w_req_b;
            r_mode       <= w_req_mode;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            if (!w_req_legal) begin
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= w_grant_id;
              r_rsp_data  <= '0;
              r_rsp_flag  <= 1'b0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // The ALU is sensitivity-driven: its inputs change only here.
          r_alu_op   <= r_op;
          r_alu_res  <= r_a;
          r_alu_reg  <= r_b;
          r_alu_eq   <= r_mode[MODE_EQ_BIT];
          r_alu_ltgt <= r_mode[MODE_LTGT_MSB:0];
          r_cnt      <= 4'(SETTLE_CYCLES);
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= alu_out;
            r_rsp_flag  <= alu_compres;
            r_rsp_err   <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
